// File: rtl/core_if_ctrl.sv
// Instruction-fetch controller: sequences L1 I-cache requests, holds fetch on
// hazards, steers the PC mux on redirects and traps a stuck cache into ERR.
module core_if_ctrl #(
  parameter int TMO_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             icache_ack,
  input  logic             hazard,
  input  logic             redir_val,
  input  logic [31:0]      redir_addr,
  output logic             if_val,
  output logic             if_pc_stop,
  output logic             if_enb,
  output logic             if_kill,
  output logic             if_mux1_trn_pc_4_s,
  output logic [31:0]      if_mux1_addr,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, REQ, STALL, REDIR, ERR} state_t;

  // Last counter value before the timeout fires; the next no-ack cycle trips ERR.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);

  state_t             state_q, state_d;
  logic               pend_q, pend_d;
  logic [31:0]        addr_q, addr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_now;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    pend_d             = pend_q;
    addr_d             = addr_q;
    tmo_d              = '0;
    cnt_d              = cnt_q;
    if_val             = 1'b0;
    if_pc_stop         = 1'b1;
    if_enb             = 1'b0;
    if_kill            = 1'b0;
    if_mux1_trn_pc_4_s = 1'b0;
    pend_now           = pend_q | redir_val;

    // Newest redirect wins; the address register doubles as the mux output.
    if (redir_val && state_q != ERR) begin
      pend_d = 1'b1;
      addr_d = redir_addr;
    end

    case (state_q)
      IDLE: state_d = pend_now ? REDIR : REQ;
      REQ: begin
        if_val = 1'b1;
        if (icache_ack) begin
          if (pend_now) begin
            state_d = REDIR;
          end else if (hazard) begin
            state_d = STALL;
          end else begin
            if_enb     = 1'b1;
            if_pc_stop = 1'b0;
            cnt_d      = cnt_q + CNT_W'(1);
          end
        end else begin
          // A redirect never abandons the outstanding request: keep waiting.
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_LAST) state_d = ERR;
        end
      end
      STALL: begin
        if (pend_now)     state_d = REDIR;
        else if (!hazard) state_d = REQ;
      end
      REDIR: begin
        if_mux1_trn_pc_4_s = 1'b1;
        if_kill            = 1'b1;
        if_enb             = 1'b1;
        if_pc_stop         = 1'b0;
        if (!redir_val) pend_d = 1'b0;
        state_d = redir_val ? REDIR : REQ;
      end
      ERR: state_d = ERR;
      default: state_d = IDLE;
    endcase

    // Control outputs stay quiet while reset is held, whatever the state was.
    if (!rst_n) begin
      if_val             = 1'b0;
      if_pc_stop         = 1'b1;
      if_enb             = 1'b0;
      if_kill            = 1'b0;
      if_mux1_trn_pc_4_s = 1'b0;
    end
  end

  assign if_mux1_addr = addr_q;
  assign fetch_cnt    = cnt_q;
  assign err          = (state_q == ERR);

endmodule

// File: tb/tb_core_if_ctrl.sv
// Directed and randomized checks of core_if_ctrl against a flag-based
// behavioural model of the fetch rules.
module tb_core_if_ctrl;
  localparam int TMO_W = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, icache_ack, hazard, redir_val;
  logic [31:0]      redir_addr;
  logic             if_val, if_pc_stop, if_enb, if_kill, if_mux1_trn_pc_4_s, err;
  logic [31:0]      if_mux1_addr;
  logic [CNT_W-1:0] fetch_cnt;

  core_if_ctrl #(.TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .icache_ack(icache_ack), .hazard(hazard),
    .redir_val(redir_val), .redir_addr(redir_addr), .if_val(if_val),
    .if_pc_stop(if_pc_stop), .if_enb(if_enb), .if_kill(if_kill),
    .if_mux1_trn_pc_4_s(if_mux1_trn_pc_4_s), .if_mux1_addr(if_mux1_addr),
    .fetch_cnt(fetch_cnt), .err(err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: one-cycle boot after reset, then fetching / stalled / redirecting / dead.
  bit          m_boot, m_redir, m_stall, m_dead, m_pend;
  logic [31:0] m_addr;
  int          m_wait, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_redir = 0; m_stall = 0; m_dead = 0; m_pend = 0;
    m_addr = 32'h0; m_wait = 0; m_cnt = 0;
  endtask

  task automatic cyc(input bit r, input bit a, input bit h, input bit rv, input logic [31:0] ra);
    bit e_val, e_stop, e_enb, e_kill, e_sel, pn, was_redir;
    rst_n = r; icache_ack = a; hazard = h; redir_val = rv; redir_addr = ra;
    @(negedge clk);
    e_val = 0; e_stop = 1; e_enb = 0; e_kill = 0; e_sel = 0;
    pn = m_pend | rv;
    if (r && !m_dead && !m_boot) begin
      if (m_redir) begin
        e_sel = 1; e_kill = 1; e_enb = 1; e_stop = 0;
      end else if (!m_stall) begin
        e_val = 1;
        if (a && !pn && !h) begin e_enb = 1; e_stop = 0; end
      end
    end
    chk("if_val", {31'b0, if_val}, {31'b0, e_val});
    chk("if_pc_stop", {31'b0, if_pc_stop}, {31'b0, e_stop});
    chk("if_enb", {31'b0, if_enb}, {31'b0, e_enb});
    chk("if_kill", {31'b0, if_kill}, {31'b0, e_kill});
    chk("if_mux1_sel", {31'b0, if_mux1_trn_pc_4_s}, {31'b0, e_sel});
    chk("if_mux1_addr", if_mux1_addr, m_addr);
    chk("fetch_cnt", {24'b0, fetch_cnt}, m_cnt);
    chk("err", {31'b0, err}, {31'b0, m_dead});
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else if (!m_dead) begin
      was_redir = m_redir;
      if (m_boot) begin
        m_boot = 0; m_redir = pn; m_wait = 0;
      end else if (m_redir) begin
        m_redir = rv; m_wait = 0;
      end else if (m_stall) begin
        if (pn) begin m_stall = 0; m_redir = 1; end
        else if (!h) begin m_stall = 0; m_wait = 0; end
      end else if (a) begin
        m_wait = 0;
        if (pn) m_redir = 1;
        else if (h) m_stall = 1;
        else m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end else begin
        m_wait++;
        if (m_wait == (1 << TMO_W) - 1) m_dead = 1;
      end
      if (rv) begin m_pend = 1; m_addr = ra; end
      else if (was_redir) m_pend = 0;
    end
    #1;
  endtask

  initial begin
    rst_n = 0; icache_ack = 0; hazard = 0; redir_val = 0; redir_addr = 32'h0;
    @(posedge clk); #1;
    model_reset();
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);

    // Streaming fetch with ack tied high.
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0);
    chk("cnt_after_10", {24'b0, fetch_cnt}, 32'd10);

    // Ack delayed three cycles.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("cnt_delayed_ack", {24'b0, fetch_cnt}, 32'd11);

    // Redirect while a request is outstanding.
    cyc(1, 0, 0, 1, 32'h400); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0);
    chk("cnt_no_count_redir", {24'b0, fetch_cnt}, 32'd11);
    cyc(1, 1, 0, 0, 0);
    chk("redir_addr_400", if_mux1_addr, 32'h400);
    cyc(1, 1, 0, 0, 0);

    // Hazard stall, then redirect overriding a persistent hazard.
    cyc(1, 1, 1, 0, 0); cyc(1, 0, 1, 0, 0); cyc(1, 0, 1, 1, 32'h800);
    cyc(1, 0, 1, 0, 0); cyc(1, 1, 0, 0, 0);

    // Two redirects during one outstanding request: newest address wins.
    cyc(1, 0, 0, 1, 32'h100); cyc(1, 0, 0, 1, 32'h200); cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("redir_newest", if_mux1_addr, 32'h200);
    cyc(1, 1, 0, 0, 0);

    // Timeout into ERR; redirect ignored there; reset recovers.
    for (int i = 0; i < 18; i++) cyc(1, 0, 0, 0, 0);
    chk("err_set", {31'b0, err}, 32'd1);
    cyc(1, 0, 0, 1, 32'hDEAD0000); cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("err_cleared", {31'b0, err}, 32'd0);

    // Counter wrap: boot cycle plus 258 accepted fetches.
    for (int i = 0; i < 259; i++) cyc(1, 1, 0, 0, 0);
    chk("cnt_wrap", {24'b0, fetch_cnt}, 32'd2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(99) != 0), ($urandom_range(9) < 7), ($urandom_range(9) < 2),
          ($urandom_range(19) == 0), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/core_if_ctrl.md
CORE_IF_CTRL -- requirements
Module: core_if_ctrl

Interface
REQ-001 Parameter TMO_W, default 8: width of the ack-timeout counter; timeout at 2^TMO_W-1 cycles.
REQ-002 Parameter CNT_W, default 32: width of the accepted-fetch counter.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 icache_ack  input  1  L1 I-cache returned the word for the outstanding request.
REQ-006 hazard  input  1  decode hazard; fetch must hold.
REQ-007 redir_val  input  1  branch/jump redirect request, single-cycle pulse.
REQ-008 redir_addr  input  32  redirect target, valid with redir_val.
REQ-009 if_val  output  1  request valid to L1 I-cache.
REQ-010 if_pc_stop  output  1  hold the fetch PC.
REQ-011 if_enb  output  1  enable the fetch/decode register.
REQ-012 if_kill  output  1  clear the fetch/decode register.
REQ-013 if_mux1_trn_pc_4_s  output  1  select redirect address as next PC.
REQ-014 if_mux1_addr  output  32  redirect address to the fetch PC mux.
REQ-015 fetch_cnt  output  CNT_W  number of accepted fetches.
REQ-016 err  output  1  sticky I-cache timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, REQ, STALL, REDIR, ERR; outputs are Moore-decoded from state except if_enb/if_pc_stop in REQ, which depend on icache_ack and hazard in the same cycle.
REQ-018 IDLE: if_val=0, if_pc_stop=1, if_enb=0; next state REQ after one cycle (REDIR if a redirect is pending).
REQ-019 REQ: if_val=1; icache_ack=1 & hazard=0 & no redirect pending -> if_enb=1, if_pc_stop=0, fetch_cnt+1, stay REQ.
REQ-020 REQ without icache_ack: if_enb=0, if_pc_stop=1, stay REQ, timeout counter +1.
REQ-021 REQ with icache_ack=1 & hazard=1: if_enb=0, if_pc_stop=1, no count, go STALL (word refetched later).
REQ-022 REQ with icache_ack=1 and a redirect pending (or redir_val in same cycle): if_enb=0, if_pc_stop=1, no count, go REDIR.
REQ-023 Redirect SHALL never abandon an outstanding request; if_val stays 1 until icache_ack.
REQ-024 redir_val SHALL set redir_pend and capture redir_addr in any state except ERR; a later redir_val before consumption overwrites the address (newest wins).
REQ-025 STALL: if_val=0, if_enb=0, if_pc_stop=1; redirect pending -> REDIR (priority over hazard); else hazard=0 -> REQ; else stay.
REQ-026 REDIR (exactly one cycle): if_mux1_trn_pc_4_s=1, if_mux1_addr=captured address, if_kill=1, if_enb=1, if_pc_stop=0, if_val=0; clears redir_pend unless redir_val asserted that same cycle; next REQ (REDIR again if re-pended).
REQ-027 if_kill and if_mux1_trn_pc_4_s SHALL be 1 only in REDIR; if_mux1_addr holds last captured address otherwise.
REQ-028 Timeout counter clears on entering REQ and on every icache_ack; reaching 2^TMO_W-1 in REQ -> ERR.
REQ-029 ERR: err=1, if_val=0, if_enb=0, if_pc_stop=1, if_kill=0; redir_val ignored; exit only via reset.
REQ-030 fetch_cnt SHALL wrap from 2^CNT_W-1 to 0 without flag.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE, clear redir_pend, timeout counter, fetch_cnt, err, if_mux1_addr=0 regardless of state, including mid-request or ERR.
REQ-032 During and in the cycle after reset: if_val=0, if_enb=0, if_pc_stop=1, if_kill=0, if_mux1_trn_pc_4_s=0.

Verification
REQ-033 Reset release, icache_ack tied 1, hazard=0 -> IDLE 1 cycle, then if_val=1 and if_enb=1 every cycle; fetch_cnt=10 after 10 REQ cycles.
REQ-034 In REQ, ack delayed 3 cycles -> if_val held 4 cycles, if_pc_stop=1 for 3, fetch_cnt +1 only on ack cycle.
REQ-035 redir_val with redir_addr=0x0000_0400 while request outstanding, ack 2 cycles later -> no fetch counted, next cycle if_kill=1, if_mux1_trn_pc_4_s=1, if_mux1_addr=0x400, then REQ.
REQ-036 hazard=1 with ack -> STALL, if_val=0 while hazard=1; redir_val during STALL -> REDIR next cycle even though hazard still 1.
REQ-037 Two redir_val pulses (0x100 then 0x200) during one outstanding request -> single REDIR cycle with if_mux1_addr=0x200.
REQ-038 TMO_W=4, icache_ack held 0 -> err=1 after 15 REQ cycles, all outputs idle; rst_n=0 one cycle -> err=0, IDLE.
